// File: rtl/microgreen_tray_scheduler.sv
// ============================================================================
// Module      : microgreen_tray_scheduler
// Description : Round-robin scheduler feeding one tray's features at a time
//               to a classifier core and reporting each decision or timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module microgreen_tray_scheduler #(
  parameter int TIMEOUT   = 12,
  parameter int NUM_TRAYS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [3:0]  req,
  input  logic [63:0] feat_in,
  output logic [3:0]  ack,
  output logic        cls_start,
  output logic [15:0] cls_features,
  input  logic        cls_done,
  input  logic        cls_result,
  output logic        result_valid,
  output logic [1:0]  result_tray,
  output logic        result_class,
  output logic        result_timeout,
  output logic [3:0]  ready_map,
  output logic [7:0]  ready_count,
  output logic        busy
);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_grant  = 3'd1;
  localparam logic [2:0] c_st_launch = 3'd2;
  localparam logic [2:0] c_st_wait   = 3'd3;
  localparam logic [2:0] c_st_report = 3'd4;

  localparam logic [3:0] c_timeout = 4'(TIMEOUT);

  logic [2:0]  r_state;
  logic [1:0]  r_winner;
  logic [1:0]  r_rr_ptr;
  logic [3:0]  r_cnt;
  logic [15:0] r_feat;
  logic [1:0]  r_res_tray;
  logic        r_res_class;
  logic        r_res_timeout;
  logic [3:0]  r_ready_map;
  logic [7:0]  r_ready_count;

  logic [1:0]  w_pick;
  logic        w_found;
  logic [3:0]  w_cnt_next;

  // Scan from the highest offset down so the nearest requester above rr_ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_rr_ptr;
    for (int i = NUM_TRAYS - 1; i >= 0; i--) begin
      if (req[r_rr_ptr + 2'(i)]) begin
        w_pick  = r_rr_ptr + 2'(i);
        w_found = 1'b1;
      end
    end
  end

  assign w_cnt_next = r_cnt + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= c_st_idle;
      r_winner      <= 2'd0;
      r_rr_ptr      <= 2'd0;
      r_cnt         <= 4'd0;
      r_feat        <= 16'd0;
      r_res_tray    <= 2'd0;
      r_res_class   <= 1'b0;
      r_res_timeout <= 1'b0;
      r_ready_map   <= 4'd0;
      r_ready_count <= 8'd0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (enable && w_found) begin
            r_winner <= w_pick;
            r_state  <= c_st_grant;
          end
        end
        c_st_grant: begin
          r_feat  <= feat_in[{r_winner, 4'b0000} +: 16];
          r_state <= c_st_launch;
        end
        c_st_launch: begin
          r_cnt   <= 4'd0;
          r_state <= c_st_wait;
        end
        c_st_wait: begin
          r_cnt <= w_cnt_next;
          // A result arriving on the timeout cycle still counts as a real result.
          if (cls_done) begin
            r_res_tray    <= r_winner;
            r_res_class   <= cls_result;
            r_res_timeout <= 1'b0;
            r_state       <= c_st_report;
          end else if (w_cnt_next == c_timeout) begin
            r_res_tray    <= r_winner;
            r_res_class   <= 1'b0;
            r_res_timeout <= 1'b1;
            r_state       <= c_st_report;
          end
        end
        c_st_report: begin
          r_ready_map[r_winner] <= r_res_class;
          if (r_res_class && (r_ready_count != 8'hFF)) begin
            r_ready_count <= r_ready_count + 8'd1;
          end
          r_rr_ptr <= r_winner + 2'd1;
          r_state  <= c_st_idle;
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign ack            = (r_state == c_st_grant) ? (4'b0001 << r_winner) : 4'b0000;
  assign cls_start      = (r_state == c_st_launch);
  assign cls_features   = r_feat;
  assign result_valid   = (r_state == c_st_report);
  assign result_tray    = r_res_tray;
  assign result_class   = r_res_class;
  assign result_timeout = r_res_timeout;
  assign ready_map      = r_ready_map;
  assign ready_count    = r_ready_count;
  assign busy           = (r_state != c_st_idle);

endmodule

`default_nettype wire

// File: tb/tb_microgreen_tray_scheduler.sv
// ============================================================================
// Module      : tb_microgreen_tray_scheduler
// Description : Self-checking bench: vector table plus scoreboard of results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_microgreen_tray_scheduler;

  localparam int TIMEOUT = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [3:0]  req;
  logic [63:0] feat_in;
  logic        cls_done;
  logic        cls_result;
  logic [3:0]  ack;
  logic        cls_start;
  logic [15:0] cls_features;
  logic        result_valid;
  logic [1:0]  result_tray;
  logic        result_class;
  logic        result_timeout;
  logic [3:0]  ready_map;
  logic [7:0]  ready_count;
  logic        busy;

  always #5 clk = ~clk;

  microgreen_tray_scheduler #(.TIMEOUT(TIMEOUT), .NUM_TRAYS(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .req(req), .feat_in(feat_in),
    .ack(ack), .cls_start(cls_start), .cls_features(cls_features),
    .cls_done(cls_done), .cls_result(cls_result),
    .result_valid(result_valid), .result_tray(result_tray),
    .result_class(result_class), .result_timeout(result_timeout),
    .ready_map(ready_map), .ready_count(ready_count), .busy(busy)
  );

  typedef struct {
    logic [3:0]  req;
    logic [63:0] feat;
    int          done_k;
    logic        res;
    logic [1:0]  exp_tray;
  } vec_t;

  typedef struct {
    logic [1:0] tray;
    logic       cls;
    logic       to;
    int         lat;
  } exp_t;

  exp_t        sb[$];
  exp_t        r_mon_exp;
  vec_t        vecs[9];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          grant_cyc = 0;
  logic [3:0]  m_map;
  int          m_count;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // Scoreboard consumer: every reported job must match the oldest expectation.
  always @(negedge clk) begin
    cyc++;
    if (ack != 4'b0000) grant_cyc = cyc;
    if (result_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_result: got result for tray %0d, required none", result_tray);
      end else begin
        r_mon_exp = sb.pop_front();
        chk("result_tray", result_tray, r_mon_exp.tray);
        chk("result_class", result_class, r_mon_exp.cls);
        chk("result_timeout", result_timeout, r_mon_exp.to);
        chk("result_latency", cyc - grant_cyc, r_mon_exp.lat);
      end
    end
  end

  task automatic run_job(input logic [3:0] r, input logic [63:0] f, input int dk,
                         input logic res, input logic hold, input logic [1:0] et);
    exp_t        e;
    logic        got;
    logic [15:0] ef;
    e.tray = et;
    if (dk >= 0 && dk < TIMEOUT) begin
      e.cls = res; e.to = 1'b0; e.lat = 3 + dk;
    end else begin
      e.cls = 1'b0; e.to = 1'b1; e.lat = 2 + TIMEOUT;
    end
    ef = f[int'(et) * 16 +: 16];
    sb.push_back(e);
    m_map[et] = e.cls;
    if (e.cls && m_count < 255) m_count++;
    req = r; feat_in = f; enable = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (ack != 4'b0000) got = 1'b1;
    end
    if (!got) begin
      n_checks++;
      $display("FAIL grant_wait: no ack in 8 cycles, required ack %b", 4'b0001 << et);
      void'(sb.pop_back());
      return;
    end
    chk("ack_onehot", ack, 4'b0001 << et);
    if (!hold) req[et] = 1'b0;
    enable = 1'b0;
    // Strobe the classifier outside WAIT; the scheduler must ignore it.
    cls_done = 1'b1; cls_result = 1'b1;
    @(negedge clk);
    chk("ack_pulse", ack, 4'b0000);
    chk("cls_start", cls_start, 1'b1);
    chk("cls_features", cls_features, ef);
    got = 1'b0;
    for (int k = 0; k < TIMEOUT + 4 && !got; k++) begin
      @(posedge clk); #1;
      cls_done = (k == dk); cls_result = res;
      @(negedge clk);
      if (result_valid) got = 1'b1;
    end
    if (!got) begin
      n_checks++;
      $display("FAIL result_wait: no result_valid in %0d cycles after launch", TIMEOUT + 4);
    end
    @(posedge clk); #1;
    cls_done = 1'b0;
    chk("ready_map", ready_map, m_map);
    chk("ready_count", ready_count, m_count);
    chk("busy_idle", busy, 1'b0);
  endtask

  task automatic clean_reset();
    @(posedge clk); #1;
    rst = 1'b1; req = 4'b0000; enable = 1'b0; cls_done = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_map = 4'b0000; m_count = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       got;
    logic       stray;
    logic [63:0] f;

    rst = 1'b1; enable = 1'b0; req = 4'b0000; feat_in = 64'd0;
    cls_done = 1'b0; cls_result = 1'b0;
    m_map = 4'b0000; m_count = 0;

    vecs[0] = '{4'b0001, 64'h9ABC_5678_1234_F8A3, 1,  1'b1, 2'd0};
    vecs[1] = '{4'b0011, 64'h1111_2222_3333_4444, 0,  1'b0, 2'd1};
    vecs[2] = '{4'b1100, 64'hDEAD_BEEF_CAFE_0123, -1, 1'b1, 2'd2};
    vecs[3] = '{4'b1111, 64'h0F0F_A5A5_5A5A_F0F0, 11, 1'b1, 2'd3};
    vecs[4] = '{4'b0110, 64'h7654_3210_FEDC_BA98, 5,  1'b1, 2'd1};
    vecs[5] = '{4'b1000, 64'hAAAA_5555_CCCC_3333, 2,  1'b0, 2'd3};
    vecs[6] = '{4'b0001, 64'h0123_4567_89AB_CDEF, 0,  1'b0, 2'd0};
    vecs[7] = '{4'b0101, 64'h8001_4002_2004_1008, 3,  1'b1, 2'd2};
    vecs[8] = '{4'b0011, 64'h13579_BDF0_2468_ACE, 12, 1'b1, 2'd0};

    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("reset_outputs",
        {ack, cls_start, cls_features, result_valid, result_tray, result_class,
         result_timeout, ready_map, ready_count, busy}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_job(vecs[i].req, vecs[i].feat, vecs[i].done_k, vecs[i].res, 1'b0, vecs[i].exp_tray);
    end

    // Reset in the middle of WAIT: the job vanishes without a report.
    f = {$urandom, $urandom};
    req = 4'b0010; feat_in = f; enable = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (cls_start) got = 1'b1;
    end
    chk("mid_reset_launch_seen", got, 1'b1);
    enable = 1'b0;
    @(posedge clk); @(posedge clk); @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_reset_busy", busy, 1'b0);
    chk("mid_reset_features", cls_features, 16'd0);
    chk("mid_reset_map_count", {ready_map, ready_count}, 12'd0);
    chk("mid_reset_result", {result_valid, result_tray, result_class, result_timeout}, 5'd0);
    req = 4'b0000;
    @(posedge clk); #1;
    rst = 1'b0;
    m_map = 4'b0000; m_count = 0;
    repeat (3) @(posedge clk);
    #1;
    run_job(4'b0100, {$urandom, $urandom}, 0, 1'b1, 1'b0, 2'd2);

    // Held requests from every tray rotate 0,1,2,3,0 after reset.
    clean_reset();
    for (int i = 0; i < 5; i++) begin
      run_job(4'b1111, {$urandom, $urandom}, 0, 1'b1, 1'b1, 2'(i % 4));
    end

    // Drive the harvest counter into saturation; rr_ptr now sits at 1.
    for (int i = 0; i < 256; i++) begin
      run_job(4'b1111, {$urandom, $urandom}, 0, 1'b1, 1'b1, 2'((1 + i) % 4));
    end
    chk("ready_count_saturated", ready_count, 8'd255);

    enable = 1'b0; req = 4'b1111;
    stray = 1'b0;
    repeat (20) begin
      @(negedge clk);
      stray = stray | busy | (|ack);
    end
    chk("disabled_no_grant", stray, 1'b0);
    chk("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
